// File: rtl/tx_serial_7e2_if.sv
// tx_serial_7e2_if: start/done handshake between the control unit and the serial transmitter
interface tx_serial_7e2_if;
  logic       partida;
  logic [6:0] dados_ascii;
  logic       pronto;
  logic       ocupado;
  modport master (output partida, dados_ascii, input pronto, ocupado);
  modport slave  (input partida, dados_ascii, output pronto, ocupado);
endinterface

// File: rtl/tx_serial_7e2.sv
// tx_serial_7e2: 7E2 async serial transmitter (start, 7 data LSB first, even parity, 2 stop)
module tx_serial_7e2 #(
  parameter int BAUD_DIV = 434,
  parameter int DIV_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             zera,
  tx_serial_7e2_if.slave   bus,
  output logic             saida_serial,
  output logic [3:0]       db_estado
);
  typedef enum logic [3:0] {IDLE = 4'b0000, PREP = 4'b0001, TX = 4'b0010, FINAL = 4'b0011} state_t;
  state_t             state, state_n;
  logic [10:0]        shreg, shreg_n;
  logic [DIV_W-1:0]   baud, baud_n;
  logic [3:0]         bit_cnt, bit_n;
  logic               saida_n;
  logic               wrap;
  assign wrap = baud == DIV_W'(BAUD_DIV - 1);
  // saida_n tracks the shift register's next bit 0 so the line is low from the first TX cycle
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    baud_n  = baud;
    bit_n   = bit_cnt;
    saida_n = 1'b1;
    case (state)
      IDLE:  state_n = bus.partida ? PREP : IDLE;
      PREP: begin
        shreg_n = {2'b11, ^bus.dados_ascii, bus.dados_ascii, 1'b0};
        baud_n  = '0;
        bit_n   = '0;
        saida_n = 1'b0;
        state_n = TX;
      end
      TX: begin
        baud_n  = wrap ? '0 : baud + DIV_W'(1);
        shreg_n = wrap ? {1'b1, shreg[10:1]} : shreg;
        bit_n   = wrap ? bit_cnt + 4'd1 : bit_cnt;
        state_n = (wrap && bit_cnt == 4'd10) ? FINAL : TX;
        saida_n = (wrap && bit_cnt == 4'd10) ? 1'b1 : shreg_n[0];
      end
      FINAL: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      shreg        <= '0;
      baud         <= '0;
      bit_cnt      <= '0;
      saida_serial <= 1'b1;
    end else if (zera) begin
      state        <= IDLE;
      shreg        <= '0;
      baud         <= '0;
      bit_cnt      <= '0;
      saida_serial <= 1'b1;
    end else begin
      state        <= state_n;
      shreg        <= shreg_n;
      baud         <= baud_n;
      bit_cnt      <= bit_n;
      saida_serial <= saida_n;
    end
  end
  assign bus.pronto  = state == FINAL;
  assign bus.ocupado = state == PREP || state == TX;
  assign db_estado   = (state inside {IDLE, PREP, TX, FINAL}) ? state : 4'hF;
endmodule
